// File: rtl/dco_phase_accumulator.sv
// DCO stage of the all-digital PLL: clamped FCW, modulo-2^PHASE_W phase accumulator, feedback divider.
// Optional scan chain over phase/fcw is enabled by defining DCO_SCAN_CHAIN_EN.
module dco_phase_accumulator #(
  parameter int                 PHASE_W    = 24,
  parameter logic [PHASE_W-1:0] FCW_BASE   = 24'h010000,
  parameter int                 KDCO_SHIFT = 4,
  parameter logic [PHASE_W-1:0] FCW_MIN    = 24'h001000,
  parameter logic [PHASE_W-1:0] FCW_MAX    = 24'h080000,
  parameter int                 DIV_N      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [15:0] ctrl,
  output logic [PHASE_W-1:0] fcw,
  output logic [PHASE_W-1:0] phase,
  output logic               dco_out,
  output logic               wrap,
  output logic               fb_tick,
  output logic               fb_clk,
  output logic               sat_hi,
  output logic               sat_lo
`ifdef DCO_SCAN_CHAIN_EN
  ,
  input  logic               scan_in,
  input  logic               scan_en,
  output logic               scan_out
`endif
);

  // Two guard bits above the widest operand keep the signed sum free of overflow.
  localparam int RAW_W = ((PHASE_W > 16 + KDCO_SHIFT) ? PHASE_W : 16 + KDCO_SHIFT) + 2;
  localparam int CNT_W = $clog2(DIV_N);
  localparam logic signed [RAW_W-1:0] BASE_EXT = RAW_W'(FCW_BASE);
  localparam logic signed [RAW_W-1:0] MIN_EXT  = RAW_W'(FCW_MIN);
  localparam logic signed [RAW_W-1:0] MAX_EXT  = RAW_W'(FCW_MAX);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DIV_N - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dco_q, dco_d;
  logic               wrap_q, wrap_d;
  logic               tick_q, tick_d;
  logic               fbclk_q, fbclk_d;
  logic               hi_q, hi_d;
  logic               lo_q, lo_d;

  logic signed [RAW_W-1:0] ctrl_ext;
  logic signed [RAW_W-1:0] raw;
  logic [PHASE_W:0]        sum;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    phase_d  = phase_q;
    fcw_d    = fcw_q;
    cnt_d    = cnt_q;
    dco_d    = dco_q;
    fbclk_d  = fbclk_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    wrap_d   = 1'b0;
    tick_d   = 1'b0;
    ctrl_ext = {{(RAW_W-16){ctrl[15]}}, ctrl};
    raw      = BASE_EXT + (ctrl_ext <<< KDCO_SHIFT);
    sum      = {1'b0, phase_q} + {1'b0, fcw_q};

`ifdef DCO_SCAN_CHAIN_EN
    if (scan_en) begin
      phase_d = {phase_q[PHASE_W-2:0], scan_in};
      fcw_d   = {fcw_q[PHASE_W-2:0], phase_q[PHASE_W-1]};
    end else
`endif
    if (en) begin
      if (raw < MIN_EXT) begin
        fcw_d = FCW_MIN;
        hi_d  = 1'b0;
        lo_d  = 1'b1;
      end else if (raw > MAX_EXT) begin
        fcw_d = FCW_MAX;
        hi_d  = 1'b1;
        lo_d  = 1'b0;
      end else begin
        fcw_d = raw[PHASE_W-1:0];
        hi_d  = 1'b0;
        lo_d  = 1'b0;
      end

      // The phase integrates the previously registered fcw, giving one extra edge of latency.
      phase_d = sum[PHASE_W-1:0];
      wrap_d  = sum[PHASE_W];
      dco_d   = sum[PHASE_W-1];
      if (sum[PHASE_W]) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          fbclk_d = ~fbclk_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      fcw_q   <= FCW_BASE;
      cnt_q   <= '0;
      dco_q   <= 1'b0;
      wrap_q  <= 1'b0;
      tick_q  <= 1'b0;
      fbclk_q <= 1'b0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      fcw_q   <= fcw_d;
      cnt_q   <= cnt_d;
      dco_q   <= dco_d;
      wrap_q  <= wrap_d;
      tick_q  <= tick_d;
      fbclk_q <= fbclk_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign phase   = phase_q;
  assign fcw     = fcw_q;
  assign dco_out = dco_q;
  assign wrap    = wrap_q;
  assign fb_tick = tick_q;
  assign fb_clk  = fbclk_q;
  assign sat_hi  = hi_q;
  assign sat_lo  = lo_q;
`ifdef DCO_SCAN_CHAIN_EN
  assign scan_out = fcw_q[PHASE_W-1];
`endif

endmodule

// File: tb/tb_dco_phase_accumulator.sv
// Self-checking bench for dco_phase_accumulator: directed scenarios plus randomized ctrl/en/rst
// compared every cycle against an arithmetic reference model.
module tb_dco_phase_accumulator;

  localparam longint MOD      = 64'd1 << 24;
  localparam longint BASE     = 64'h010000;
  localparam longint FMIN     = 64'h001000;
  localparam longint FMAX     = 64'h080000;
  localparam int     DIVN     = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [15:0] ctrl;
  logic [23:0]        fcw;
  logic [23:0]        phase;
  logic               dco_out, wrap, fb_tick, fb_clk, sat_hi, sat_lo;

  dco_phase_accumulator dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .ctrl   (ctrl),
    .fcw    (fcw),
    .phase  (phase),
    .dco_out(dco_out),
    .wrap   (wrap),
    .fb_tick(fb_tick),
    .fb_clk (fb_clk),
    .sat_hi (sat_hi),
    .sat_lo (sat_lo)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state, in plain integers.
  longint m_phase, m_fcw;
  int     m_wraps;
  bit     m_dco, m_wrap, m_tick, m_fbclk, m_hi, m_lo;

  task automatic model_edge();
    longint raw, total;
    if (rst) begin
      m_phase = 0; m_fcw = BASE; m_wraps = 0;
      m_dco = 0; m_wrap = 0; m_tick = 0; m_fbclk = 0; m_hi = 0; m_lo = 0;
    end else if (en) begin
      total   = m_phase + m_fcw;
      m_wrap  = (total >= MOD);
      m_phase = total % MOD;
      m_dco   = (m_phase >= MOD / 2);
      m_tick  = 0;
      if (m_wrap) begin
        m_wraps++;
        if (m_wraps % DIVN == 0) begin
          m_tick  = 1;
          m_fbclk = ~m_fbclk;
        end
      end
      raw  = BASE + longint'(ctrl) * 16;
      m_hi = (raw > FMAX);
      m_lo = (raw < FMIN);
      m_fcw = m_hi ? FMAX : (m_lo ? FMIN : raw);
    end else begin
      m_wrap = 0;
      m_tick = 0;
    end
  endtask

  task automatic compare_all();
    check("phase",   phase,   m_phase);
    check("fcw",     fcw,     m_fcw);
    check("dco_out", dco_out, m_dco);
    check("wrap",    wrap,    m_wrap);
    check("fb_tick", fb_tick, m_tick);
    check("fb_clk",  fb_clk,  m_fbclk);
    check("sat_hi",  sat_hi,  m_hi);
    check("sat_lo",  sat_lo,  m_lo);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int     n_wrap, n_tick, n_dco, n_tog, wraps_seen, budget;
    bit     prev_fbclk, found;
    logic [23:0] p0;

    m_phase = 0; m_fcw = BASE; m_wraps = 0;
    m_dco = 0; m_wrap = 0; m_tick = 0; m_fbclk = 0; m_hi = 0; m_lo = 0;

    // Reset held two cycles with non-zero ctrl.
    rst = 1'b1; en = 1'b1; ctrl = 16'sd1234;
    cycle();
    cycle();
    check("rst_phase", phase, 0);
    check("rst_fcw", fcw, 64'h010000);
    check("rst_bits", {dco_out, wrap, fb_tick, fb_clk, sat_hi, sat_lo}, 0);

    // Free-run for one full fb_clk period.
    rst = 1'b0; ctrl = 16'sd0;
    n_wrap = 0; n_tick = 0; n_dco = 0; n_tog = 0; prev_fbclk = fb_clk;
    for (int i = 0; i < 4096; i++) begin
      cycle();
      n_wrap += int'(wrap);
      n_tick += int'(fb_tick);
      n_dco  += int'(dco_out);
      if (fb_clk != prev_fbclk) n_tog++;
      prev_fbclk = fb_clk;
    end
    check("free_wraps", n_wrap, 16);
    check("free_ticks", n_tick, 2);
    check("free_dco_high", n_dco, 2048);
    check("free_fbclk_toggles", n_tog, 2);

    // Gain and latency: fcw follows one edge later, phase increment one edge after that.
    ctrl = 16'sd16;
    p0 = phase;
    cycle();
    check("gain_fcw", fcw, 64'h010100);
    check("gain_step0", 24'(phase - p0), 64'h010000);
    check("gain_sat", {sat_hi, sat_lo}, 0);
    p0 = phase;
    cycle();
    check("gain_step1", 24'(phase - p0), 64'h010100);

    // Clamp extremes.
    ctrl = 16'sd32767;
    cycle();
    check("clamp_hi_fcw", fcw, 64'h080000);
    check("clamp_hi_flag", {sat_hi, sat_lo}, 2'b10);
    ctrl = -16'sd32768;
    cycle();
    check("clamp_lo_fcw", fcw, 64'h001000);
    check("clamp_lo_flag", {sat_hi, sat_lo}, 2'b01);
    ctrl = 16'sd0;
    cycle();
    check("clamp_clear_fcw", fcw, 64'h010000);
    check("clamp_clear_flag", {sat_hi, sat_lo}, 2'b00);

    // Randomized ctrl / en / rst.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(1, 0) == 1) ctrl = 16'($signed($urandom_range(10000, 0)) - 5000);
      else ctrl = 16'($urandom);
      en  = ($urandom_range(9, 0) != 0);
      rst = ($urandom_range(199, 0) == 0);
      cycle();
    end

    // Freeze across a due carry.
    rst = 1'b1; en = 1'b1; ctrl = 16'sd0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 255; i++) cycle();
    check("freeze_pre_phase", phase, 64'hFF0000);
    en = 1'b0;
    n_wrap = 0; n_tick = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_wrap += int'(wrap);
      n_tick += int'(fb_tick);
    end
    check("freeze_phase", phase, 64'hFF0000);
    check("freeze_fcw", fcw, 64'h010000);
    check("freeze_pulses", n_wrap + n_tick, 0);
    en = 1'b1;
    cycle();
    check("resume_wrap", wrap, 1);
    check("resume_phase", phase, 0);

    // Mid-run reset while the wrap counter is 5 and fb_clk is high.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      cycle();
      if (m_wraps % DIVN == 5 && m_fbclk) found = 1'b1;
    end
    check("midrst_reach", found, 1);
    rst = 1'b1;
    cycle();
    check("midrst_phase", phase, 0);
    check("midrst_fbclk", fb_clk, 0);
    rst = 1'b0;
    wraps_seen = 0; found = 1'b0; budget = DIVN * 256 + 16;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      wraps_seen += int'(wrap);
      if (fb_tick) found = 1'b1;
    end
    check("midrst_tick_seen", found, 1);
    check("midrst_wraps_to_tick", wraps_seen, DIVN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
